conv_scheduler: RTL and testbench

Sequences the convolution datapath once the memory reader has filled the filter and image buffers. For every filter and every output position it drives buffer read addresses and MAC control, then hands each finished partial sum to the output writer over a valid/ready handshake. It sits between the memory reader's `done` and the MAC/output-writer datapath, and pulses `done` when every filter has been swept across the image.

---
 rtl/conv_scheduler_if.sv | 29 ++
 rtl/conv_scheduler.sv | 175 +++++++++++++++++
 tb/tb_conv_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_scheduler_if.sv
// Control/handshake bundle between the convolution scheduler and its datapath.
// The master side is the scheduler; the slave side is the buffers, MAC and output writer.
interface conv_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] filt_addr;
    logic [ADDR_W-1:0] img_addr;
    logic              rd_en;
    logic              mac_clr;
    logic              mac_en;
    logic              psum_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, out_ready,
        output filt_addr, img_addr, rd_en, mac_clr, mac_en,
               psum_valid, out_addr, busy, done
    );

    modport slave (
        output start, out_ready,
        input  filt_addr, img_addr, rd_en, mac_clr, mac_en,
               psum_valid, out_addr, busy, done
    );
endinterface

// File: rtl/conv_scheduler.sv
// Sweeps every filter across a 1-D image, driving buffer addresses and MAC control,
// and hands each finished partial sum to the output writer over valid/ready.
module conv_scheduler #(
    parameter int IMG_LEN     = 16,
    parameter int FILTER_SIZE = 4,
    parameter int NUM_FILTERS = 4,
    parameter int STRIDE      = 1,
    parameter int ADDR_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    conv_scheduler_if.master   bus
);

    localparam int NUM_POS = (IMG_LEN - FILTER_SIZE) / STRIDE + 1;

    localparam logic [ADDR_W-1:0] FS_A   = ADDR_W'(FILTER_SIZE);
    localparam logic [ADDR_W-1:0] NP_A   = ADDR_W'(NUM_POS);
    localparam logic [ADDR_W-1:0] STR_A  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] T_LAST = ADDR_W'(FILTER_SIZE - 1);
    localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(NUM_POS - 1);
    localparam logic [ADDR_W-1:0] F_LAST = ADDR_W'(NUM_FILTERS - 1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] f_r, p_r, t_r;
    logic [ADDR_W-1:0] f_nx_s, p_nx_s, t_nx_s;

    logic [ADDR_W-1:0] filt_addr_s, img_addr_s, out_addr_s;
    logic              rd_en_s, mac_clr_s, psum_valid_s, busy_s, done_s;

    logic [ADDR_W-1:0] filt_addr_r, img_addr_r, out_addr_r;
    logic              rd_en_r, mac_clr_r, mac_en_r, psum_valid_r, busy_r, done_r;

    // State and sweep counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            f_r     <= '0;
            p_r     <= '0;
            t_r     <= '0;
        end else begin
            state_r <= state_nx_s;
            f_r     <= f_nx_s;
            p_r     <= p_nx_s;
            t_r     <= t_nx_s;
        end
    end

    // Next-state and next-counter decode
    always_comb begin
        state_nx_s = state_r;
        f_nx_s     = f_r;
        p_nx_s     = p_r;
        t_nx_s     = t_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    f_nx_s     = '0;
                    p_nx_s     = '0;
                    t_nx_s     = '0;
                    state_nx_s = S_CLEAR;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_CLEAR: state_nx_s = S_MAC;
            S_MAC: begin
                if (t_r == T_LAST) begin
                    t_nx_s     = '0;
                    state_nx_s = S_DRAIN;
                end else begin
                    t_nx_s     = t_r + ONE_A;
                    state_nx_s = S_MAC;
                end
            end
            S_DRAIN: state_nx_s = S_WRITE;
            S_WRITE: begin
                // psum_valid is always high in WRITE, so out_ready alone completes the handshake
                if (bus.out_ready) begin
                    if (p_r < P_LAST) begin
                        p_nx_s     = p_r + ONE_A;
                        state_nx_s = S_CLEAR;
                    end else if (f_r < F_LAST) begin
                        p_nx_s     = '0;
                        f_nx_s     = f_r + ONE_A;
                        state_nx_s = S_CLEAR;
                    end else begin
                        state_nx_s = S_DONE;
                    end
                end else begin
                    state_nx_s = S_WRITE;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        rd_en_s      = 1'b0;
        mac_clr_s    = 1'b0;
        psum_valid_s = 1'b0;
        done_s       = 1'b0;
        busy_s       = 1'b1;
        filt_addr_s  = '0;
        img_addr_s   = '0;
        out_addr_s   = '0;
        case (state_nx_s)
            S_IDLE:  busy_s       = 1'b0;
            S_CLEAR: mac_clr_s    = 1'b1;
            S_MAC:   rd_en_s      = 1'b1;
            S_DRAIN: rd_en_s      = 1'b0;
            S_WRITE: psum_valid_s = 1'b1;
            S_DONE:  done_s       = 1'b1;
            default: busy_s       = 1'b0;
        endcase
        if (state_nx_s != S_IDLE) begin
            filt_addr_s = f_nx_s * FS_A + t_nx_s;
            img_addr_s  = p_nx_s * STR_A + t_nx_s;
            out_addr_s  = f_nx_s * NP_A + p_nx_s;
        end else begin
            filt_addr_s = '0;
            img_addr_s  = '0;
            out_addr_s  = '0;
        end
    end

    // Output registers; mac_en trails rd_en by the one-cycle buffer read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_addr_r  <= '0;
            img_addr_r   <= '0;
            out_addr_r   <= '0;
            rd_en_r      <= 1'b0;
            mac_clr_r    <= 1'b0;
            mac_en_r     <= 1'b0;
            psum_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            filt_addr_r  <= filt_addr_s;
            img_addr_r   <= img_addr_s;
            out_addr_r   <= out_addr_s;
            rd_en_r      <= rd_en_s;
            mac_clr_r    <= mac_clr_s;
            mac_en_r     <= rd_en_r;
            psum_valid_r <= psum_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign bus.filt_addr  = filt_addr_r;
    assign bus.img_addr   = img_addr_r;
    assign bus.out_addr   = out_addr_r;
    assign bus.rd_en      = rd_en_r;
    assign bus.mac_clr    = mac_clr_r;
    assign bus.mac_en     = mac_en_r;
    assign bus.psum_valid = psum_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: default geometry plus a STRIDE=2 instance,
// with an out_addr scoreboard popped on every valid/ready handshake.
module tb_conv_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_scheduler_if #(.ADDR_W(8)) bus_a ();
    conv_scheduler_if #(.ADDR_W(8)) bus_b ();

    conv_scheduler #(.IMG_LEN(16), .FILTER_SIZE(4), .NUM_FILTERS(4), .STRIDE(1), .ADDR_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    conv_scheduler #(.IMG_LEN(16), .FILTER_SIZE(4), .NUM_FILTERS(4), .STRIDE(2), .ADDR_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_a    = 0;
    int hs_b    = 0;
    int exp_a[$];
    int exp_b[$];
    int dc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) exp_a.push_back(i);
    endtask

    task automatic run_done(input bit use_b, input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((use_b ? bus_b.done : bus_a.done) === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    // Scoreboard: handshake completes on the next edge, inputs are stable at the falling edge
    always @(negedge clk) begin
        if (bus_a.psum_valid && bus_a.out_ready) begin
            hs_a++;
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL a_extra_psum: observed out_addr %0d expected none", bus_a.out_addr);
            end else begin
                check("a_out_addr", 32'(bus_a.out_addr), 32'(exp_a.pop_front()));
            end
        end
        if (bus_b.psum_valid && bus_b.out_ready) begin
            hs_b++;
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL b_extra_psum: observed out_addr %0d expected none", bus_b.out_addr);
            end else begin
                check("b_out_addr", 32'(bus_b.out_addr), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        bus_a.start = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.start = 1'b0; bus_b.out_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check("a_reset_outputs", 32'({bus_a.filt_addr, bus_a.img_addr, bus_a.out_addr, bus_a.rd_en,
              bus_a.mac_clr, bus_a.mac_en, bus_a.psum_valid, bus_a.busy, bus_a.done}), 32'd0);
        check("b_reset_outputs", 32'({bus_b.filt_addr, bus_b.img_addr, bus_b.out_addr, bus_b.rd_en,
              bus_b.mac_clr, bus_b.mac_en, bus_b.psum_valid, bus_b.busy, bus_b.done}), 32'd0);
        rst = 1'b1;
        repeat (2) step();

        // Run 1: defaults, out_ready high, first-output detail
        push_a(52); hs_a = 0;
        bus_a.start = 1'b1; cyc = 0; step(); bus_a.start = 1'b0;
        check("clr_mac_clr", 32'(bus_a.mac_clr), 32'd1);
        check("clr_rd_en", 32'(bus_a.rd_en), 32'd0);
        check("clr_busy", 32'(bus_a.busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("mac_rd_en", 32'(bus_a.rd_en), 32'd1);
            check("mac_filt_addr", 32'(bus_a.filt_addr), 32'(k));
            check("mac_img_addr", 32'(bus_a.img_addr), 32'(k));
            check("mac_mac_en", 32'(bus_a.mac_en), (k > 0) ? 32'd1 : 32'd0);
        end
        step();
        check("drain_rd_en", 32'(bus_a.rd_en), 32'd0);
        check("drain_mac_en", 32'(bus_a.mac_en), 32'd1);
        step();
        check("write_valid", 32'(bus_a.psum_valid), 32'd1);
        check("write_mac_en", 32'(bus_a.mac_en), 32'd0);
        check("write_out_addr", 32'(bus_a.out_addr), 32'd0);
        run_done(1'b0, 500, dc);
        check("run1_done_cycle", 32'(dc), 32'd365);
        step();
        check("run1_busy_after", 32'(bus_a.busy), 32'd0);
        check("run1_done_pulse", 32'(bus_a.done), 32'd0);
        check("run1_handshakes", 32'(hs_a), 32'd52);
        check("run1_queue_left", 32'(exp_a.size()), 32'd0);

        // Run 2: out_ready low for 5 cycles at first WRITE, plus a stray mid-run start
        bus_a.out_ready = 1'b0;
        push_a(52); hs_a = 0;
        bus_a.start = 1'b1; cyc = 0; step(); bus_a.start = 1'b0;
        step_to(7);
        for (int i = 0; i < 6; i++) begin
            check("stall_valid", 32'(bus_a.psum_valid), 32'd1);
            check("stall_out_addr", 32'(bus_a.out_addr), 32'd0);
            check("stall_img_addr", 32'(bus_a.img_addr), 32'd0);
            if (i == 5) bus_a.out_ready = 1'b1;
            else step();
        end
        step_to(100);
        bus_a.start = 1'b1; step(); bus_a.start = 1'b0;
        run_done(1'b0, 500, dc);
        check("run2_done_cycle", 32'(dc), 32'd370);
        check("run2_handshakes", 32'(hs_a), 32'd52);

        // Run 3: STRIDE=2 instance, NUM_POS=7
        for (int i = 0; i < 28; i++) exp_b.push_back(i);
        hs_b = 0;
        step();
        bus_b.start = 1'b1; cyc = 0; step(); bus_b.start = 1'b0;
        step_to(43);
        for (int t = 0; t < 4; t++) begin
            step();
            check("s2_p6_img_addr", 32'(bus_b.img_addr), 32'(12 + t));
            check("s2_p6_filt_addr", 32'(bus_b.filt_addr), 32'(t));
        end
        step_to(99);
        for (int t = 0; t < 4; t++) begin
            step();
            check("s2_f2_filt_addr", 32'(bus_b.filt_addr), 32'(8 + t));
        end
        run_done(1'b1, 300, dc);
        check("s2_done_cycle", 32'(dc), 32'd197);
        check("s2_handshakes", 32'(hs_b), 32'd28);

        // Run 4: start held through DONE, then reset in MAC of output 10 of the second run
        step();
        push_a(52); hs_a = 0;
        bus_a.start = 1'b1; cyc = 0; step();
        run_done(1'b0, 500, dc);
        check("b2b_done_cycle", 32'(dc), 32'd365);
        check("b2b_handshakes", 32'(hs_a), 32'd52);
        step();
        check("b2b_idle_busy", 32'(bus_a.busy), 32'd0);
        push_a(52); hs_a = 0;
        step();
        bus_a.start = 1'b0;
        check("b2b_restart_clr", 32'(bus_a.mac_clr), 32'd1);
        check("b2b_restart_busy", 32'(bus_a.busy), 32'd1);
        cyc = 1;
        step_to(73);
        check("pre_rst_rd_en", 32'(bus_a.rd_en), 32'd1);
        check("pre_rst_img_addr", 32'(bus_a.img_addr), 32'd11);
        rst = 1'b0;
        #1;
        check("midrun_rst_outputs", 32'({bus_a.filt_addr, bus_a.img_addr, bus_a.out_addr, bus_a.rd_en,
              bus_a.mac_clr, bus_a.mac_en, bus_a.psum_valid, bus_a.busy, bus_a.done}), 32'd0);
        exp_a.delete();
        repeat (2) step();
        rst = 1'b1;
        step();
        check("post_rst_busy", 32'(bus_a.busy), 32'd0);

        push_a(52); hs_a = 0;
        bus_a.start = 1'b1; cyc = 0; step(); bus_a.start = 1'b0;
        check("fresh_mac_clr", 32'(bus_a.mac_clr), 32'd1);
        run_done(1'b0, 500, dc);
        check("fresh_done_cycle", 32'(dc), 32'd365);
        check("fresh_handshakes", 32'(hs_a), 32'd52);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
